instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 12'o4000, meaning first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, meaning prefetch buffer entries; only the value 2 is supported.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rom_req  output  1  fetch request to ROM.
REQ-006 rom_addr  output  12  fetch address; valid while rom_req=1.
REQ-007 rom_ack  input  1  ROM response strobe; rom_data valid in the same cycle.
REQ-008 rom_data  input  15  fetched instruction word.
REQ-009 branch_valid  input  1  redirect request from execute.
REQ-010 branch_target  input  12  redirect address; sampled only when branch_valid=1.
REQ-011 stall  input  1  decode not ready; the head entry is held.
REQ-012 halt  input  1  halt request from decode.
REQ-013 instr  output  15  head instruction word presented to decode.
REQ-014 pc  output  12  address of the head instruction.
REQ-015 instr_valid  output  1  instr/pc valid.
REQ-016 flush  output  1  one-cycle pulse to decode pipeline registers on redirect.

Function
REQ-017 The FSM SHALL have 3 states: FETCH (normal operation), DRAIN (discarding a stale in-flight response), HALTED.
REQ-018 Request rule: rom_req SHALL assert only when (buffer count + outstanding) < 2; at most one request SHALL be outstanding.
REQ-019 Once rom_req is asserted, it and rom_addr SHALL hold stable until the cycle in which rom_ack=1.
REQ-020 On rom_ack in FETCH, rom_data SHALL be written at the buffer tail together with its address, and fetch_pc SHALL increment.
REQ-021 Address arithmetic SHALL be 12-bit modulo: 12'o7777 + 1 = 12'o0000, with no carry out.
REQ-022 instr_valid SHALL be 1 iff the buffer is non-empty and the state is not HALTED.
REQ-023 Consume rule: the head SHALL be popped when instr_valid=1 and stall=0.
REQ-024 Push and pop in the same cycle SHALL leave the count unchanged, including when the buffer is full.
REQ-025 Latency: a word acked in cycle N SHALL appear on instr/instr_valid in cycle N+1 if the buffer was empty.
REQ-026 Branch: when branch_valid=1, the buffer SHALL be cleared, fetch_pc loaded with branch_target, and flush asserted for that one cycle.
REQ-027 Branch with a request outstanding and not acked in the same cycle: the state SHALL go to DRAIN; rom_req stays high on the old address until rom_ack; the ack data SHALL be discarded; then the state returns to FETCH.
REQ-028 Branch and rom_ack in the same cycle: the ack data SHALL be discarded, the state stays FETCH, and the next request goes to branch_target.
REQ-029 Branch in DRAIN: the state SHALL remain DRAIN, and fetch_pc takes the newest target.
REQ-030 Halt: on halt=1 the state SHALL go to HALTED, and instr_valid=0 from the next cycle.
REQ-031 In HALTED, any outstanding request SHALL complete with its data dropped, no new requests SHALL issue, and only rst exits the state.
REQ-032 Halt and branch in the same cycle: halt SHALL take priority, and the branch SHALL be ignored (no flush).
REQ-033 Stall SHALL never block fetching while buffer space remains.

Reset
REQ-034 While rst=1: state=FETCH, buffer empty, no request outstanding, fetch_pc=RESET_PC, rom_req=0, instr_valid=0, flush=0, instr=0, pc=0.
REQ-035 rst asserted mid-request SHALL abandon the request; the ROM is required to tolerate an abandoned request under reset.
REQ-036 rom_req SHALL first assert in the first cycle after rst deasserts, with rom_addr=RESET_PC.

Verification
REQ-037 Reset release with ROM acking every cycle -> rom_addr sequence 4000, 4001, 4002; instr_valid rises 1 cycle after the first ack; pc=4000.
REQ-038 stall=1 held for 5 cycles -> exactly 2 words buffered; rom_req=0; the head is unchanged; on release, pc advances 4000, 4001, 4002.
REQ-039 fetch_pc=7777 acked -> next rom_addr=0000, and pc sequence 7777 then 0000.
REQ-040 Branch to 2345 while request at 4003 is outstanding (ack 3 cycles later) -> flush pulses once; 4003 data never appears; next rom_addr=2345.
REQ-041 Branch to 1000 and rom_ack in the same cycle -> the acked word is dropped; the next valid pc=1000.
REQ-042 halt and branch_valid in the same cycle -> HALTED, no flush, instr_valid=0 thereafter, no rom_req until rst.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: ROM request/response channel plus the decode-side instruction
// stream and the branch/stall/halt controls from later pipeline stages.
interface instr_fetch_if;
    logic        rom_req;
    logic [11:0] rom_addr;
    logic        rom_ack;
    logic [14:0] rom_data;
    logic        branch_valid;
    logic [11:0] branch_target;
    logic        stall;
    logic        halt;
    logic [14:0] instr;
    logic [11:0] pc;
    logic        instr_valid;
    logic        flush;

    modport master (
        output rom_req, rom_addr, instr, pc, instr_valid, flush,
        input  rom_ack, rom_data, branch_valid, branch_target, stall, halt
    );

    modport slave (
        input  rom_req, rom_addr, instr, pc, instr_valid, flush,
        output rom_ack, rom_data, branch_valid, branch_target, stall, halt
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding ROM request, two-entry prefetch buffer,
// branch redirect with stale-response drain, and a sticky halt.
module instr_fetch #(
    parameter logic [11:0] RESET_PC  = 12'o4000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic          clock,
    input  logic          rst,
    instr_fetch_if.master bus
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]  r_state;
    logic [14:0] r_buf_data [2];
    logic [11:0] r_buf_pc   [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic        r_outstanding;
    logic [11:0] r_req_addr;
    logic [11:0] r_fetch_pc;

    logic        w_new_req;
    logic        w_req;
    logic [11:0] w_addr;
    logic        w_ack;
    logic        w_branch;
    logic        w_valid;
    logic        w_pop;
    logic        w_push;
    logic        w_tail;

    always_comb begin
        w_new_req = (r_state == S_FETCH) && !r_outstanding
                    && ({30'd0, r_count} < BUF_DEPTH);
        // A request stays asserted on its latched address until acked, even across a redirect.
        w_req     = !rst && (r_outstanding || w_new_req);
        w_addr    = r_outstanding ? r_req_addr : r_fetch_pc;
        w_ack     = w_req && bus.rom_ack;
        w_branch  = bus.branch_valid && !bus.halt && (r_state != S_HALTED);
        w_valid   = !rst && (r_count != 2'd0) && (r_state != S_HALTED);
        w_pop     = w_valid && !bus.stall;
        w_push    = w_ack && (r_state == S_FETCH) && !w_branch && !bus.halt;
        w_tail    = r_head ^ r_count[0];
    end

    assign bus.rom_req     = w_req;
    assign bus.rom_addr    = w_addr;
    assign bus.instr_valid = w_valid;
    assign bus.instr       = w_valid ? r_buf_data[r_head] : '0;
    assign bus.pc          = w_valid ? r_buf_pc[r_head] : '0;
    assign bus.flush       = !rst && w_branch;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_buf_data[w_tail] <= bus.rom_data;
            r_buf_pc[w_tail]   <= w_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_head        <= 1'b0;
            r_count       <= 2'd0;
            r_outstanding <= 1'b0;
            r_req_addr    <= RESET_PC;
            r_fetch_pc    <= RESET_PC;
        end else begin
            r_outstanding <= w_req && !w_ack;
            if (w_req) begin
                r_req_addr <= w_addr;
            end

            if (w_branch) begin
                r_head     <= 1'b0;
                r_count    <= 2'd0;
                r_fetch_pc <= bus.branch_target;
            end else begin
                if (w_pop) begin
                    r_head <= ~r_head;
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
                if (w_push) begin
                    r_fetch_pc <= w_addr + 12'd1;
                end
            end

            // A branch whose ack lands in the same cycle has nothing left to drain.
            case (r_state)
                S_FETCH: begin
                    if (bus.halt) begin
                        r_state <= S_HALTED;
                    end else if (w_branch && w_req && !w_ack) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.halt) begin
                        r_state <= S_HALTED;
                    end else if (w_ack) begin
                        r_state <= S_FETCH;
                    end
                end
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: reset/stream/stall vector table, directed redirect and
// halt sequences, then random traffic against a queue-based reference model.
module tb_instr_fetch;

    localparam logic [11:0] RESET_PC = 12'o4000;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // ROM contents: a distinct word per address, so a wrong pc/instr pairing shows up.
    function automatic logic [14:0] rom_word(input logic [11:0] a);
        return {a[2:0] ^ a[11:9], ~a};
    endfunction

    assign bus.rom_data = rom_word(bus.rom_addr);

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic s, input logic b,
                         input logic [11:0] t, input logic h);
        @(posedge clock);
        #1;
        rst               = r;
        bus.rom_ack       = a;
        bus.stall         = s;
        bus.branch_valid  = b;
        bus.branch_target = t;
        bus.halt          = h;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic er, input logic [11:0] ea,
                              input logic ev, input logic [11:0] ep, input logic ef);
        chk({tag, ".rom_req"}, 32'(bus.rom_req), 32'(er));
        if (er) chk({tag, ".rom_addr"}, 32'(bus.rom_addr), 32'(ea));
        chk({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(ev));
        if (ev) begin
            chk({tag, ".pc"}, 32'(bus.pc), 32'(ep));
            chk({tag, ".instr"}, 32'(bus.instr), 32'(rom_word(ep)));
        end
        chk({tag, ".flush"}, 32'(bus.flush), 32'(ef));
    endtask

    task automatic expect_reset_out(input string tag);
        expect_out(tag, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0);
        chk({tag, ".pc_rst"}, 32'(bus.pc), 32'd0);
        chk({tag, ".instr_rst"}, 32'(bus.instr), 32'd0);
    endtask

    typedef struct {
        logic        rst;
        logic        ack;
        logic        stall;
        logic        exp_req;
        logic [11:0] exp_addr;
        logic        exp_valid;
        logic [11:0] exp_pc;
    } vec_t;

    task automatic run_table();
        vec_t tbl[16];
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'o0000, 1'b0, 12'o0000};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'o0000, 1'b0, 12'o0000};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12'o4000, 1'b0, 12'o0000};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12'o4001, 1'b1, 12'o4000};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12'o4002, 1'b1, 12'o4001};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12'o4003, 1'b1, 12'o4002};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'o0000, 1'b0, 12'o0000};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 12'o4000, 1'b0, 12'o0000};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 12'o4001, 1'b1, 12'o4000};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 12'o0000, 1'b1, 12'o4000};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'o0000, 1'b1, 12'o4000};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'o0000, 1'b1, 12'o4000};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'o0000, 1'b1, 12'o4000};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'o0000, 1'b1, 12'o4000};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'o4002, 1'b1, 12'o4001};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'o4003, 1'b1, 12'o4002};
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].ack, tbl[i].stall, 1'b0, 12'd0, 1'b0);
            if (tbl[i].rst) begin
                expect_reset_out($sformatf("vec%0d", i));
            end else begin
                expect_out($sformatf("vec%0d", i), tbl[i].exp_req, tbl[i].exp_addr,
                           tbl[i].exp_valid, tbl[i].exp_pc, 1'b0);
            end
        end
    endtask

    task automatic seq_wrap();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 12'o7777, 1'b0);
        expect_out("wrap0", 1'b1, 12'o4000, 1'b0, 12'd0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        expect_out("wrap1", 1'b1, 12'o7777, 1'b0, 12'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        expect_out("wrap2", 1'b1, 12'o0000, 1'b1, 12'o7777, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        expect_out("wrap3", 1'b1, 12'o0001, 1'b1, 12'o0000, 1'b0);
    endtask

    task automatic seq_branch_drain();
        logic [11:0] exp_addr [6];
        int unsigned fl_cnt;
        logic        seen_stale;
        exp_addr   = '{12'o4003, 12'o4003, 12'o4003, 12'o4003, 12'o2345, 12'o2346};
        fl_cnt     = 0;
        seen_stale = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        expect_out("drn_a", 1'b1, 12'o4000, 1'b0, 12'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
        expect_out("drn_d", 1'b1, 12'o4003, 1'b1, 12'o4002, 1'b0);
        // Branch with 4003 in flight; the ROM answers three cycles later.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, (i >= 3), 1'b0, (i == 0), 12'o2345, 1'b0);
            expect_out($sformatf("drn%0d", i), 1'b1, exp_addr[i], (i == 5), 12'o2345, (i == 0));
            fl_cnt += 32'(bus.flush);
            if (bus.instr_valid && (bus.pc == 12'o4003 || bus.instr == rom_word(12'o4003)))
                seen_stale = 1'b1;
        end
        chk("drn_flush_count", fl_cnt, 32'd1);
        chk("drn_stale_seen", 32'(seen_stale), 32'd0);
    endtask

    task automatic seq_branch_ack();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 12'o1000, 1'b0);
        expect_out("bak0", 1'b1, 12'o4000, 1'b0, 12'd0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        expect_out("bak1", 1'b1, 12'o1000, 1'b0, 12'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        expect_out("bak2", 1'b1, 12'o1001, 1'b1, 12'o1000, 1'b0);
    endtask

    task automatic seq_halt_branch();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        expect_out("hlt_b", 1'b1, 12'o4001, 1'b1, 12'o4000, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 12'o0123, 1'b1);
        expect_out("hlt_c", 1'b1, 12'o4002, 1'b1, 12'o4001, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b0, (i == 2), 12'o0555, 1'b0);
            expect_out($sformatf("hlt%0d", i), 1'b0, 12'd0, 1'b0, 12'd0, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        expect_reset_out("hlt_rst");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        expect_out("hlt_exit", 1'b1, RESET_PC, 1'b0, 12'd0, 1'b0);
    endtask

    // Reference model: the buffer is a queue of fetched addresses; the ROM word is rom_word(addr).
    task automatic run_random(input int unsigned cycles);
        logic [11:0] m_q[$];
        logic        m_halted, m_drain, m_infl;
        logic [11:0] m_iaddr, m_fpc;
        logic        r, a, s, b, h, er, ev, ef, ack;
        logic [11:0] t, ea, ep;
        m_halted = 1'b0; m_drain = 1'b0; m_infl = 1'b0;
        m_iaddr  = RESET_PC; m_fpc = RESET_PC;
        for (int unsigned c = 0; c < cycles; c++) begin
            r = (c == 0) || ($urandom_range(0, 149) == 0);
            a = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 13) == 0);
            t = ($urandom_range(0, 3) == 0) ? 12'o7776 : 12'($urandom);
            h = ($urandom_range(0, 199) == 0);
            drive(r, a, s, b, t, h);
            if (r) begin
                expect_reset_out($sformatf("rnd%0d", c));
                m_q.delete();
                m_halted = 1'b0; m_drain = 1'b0; m_infl = 1'b0; m_fpc = RESET_PC;
            end else begin
                er = m_infl || (!m_halted && !m_drain && m_q.size() < 2);
                ea = m_infl ? m_iaddr : m_fpc;
                ev = (m_q.size() > 0) && !m_halted;
                ep = ev ? m_q[0] : 12'd0;
                ef = b && !h && !m_halted;
                expect_out($sformatf("rnd%0d", c), er, ea, ev, ep, ef);
                ack = er && a;
                if (m_halted || h) begin
                    m_halted = 1'b1;
                    m_q.delete();
                    m_infl  = er && !ack;
                    m_iaddr = ea;
                end else if (b) begin
                    m_q.delete();
                    m_fpc   = t;
                    m_infl  = er && !ack;
                    m_iaddr = ea;
                    m_drain = m_infl;
                end else begin
                    if (ev && !s) void'(m_q.pop_front());
                    if (m_drain) begin
                        if (ack) begin
                            m_drain = 1'b0;
                            m_infl  = 1'b0;
                        end
                    end else if (ack) begin
                        m_q.push_back(ea);
                        m_fpc  = ea + 12'd1;
                        m_infl = 1'b0;
                    end else begin
                        m_infl  = er;
                        m_iaddr = ea;
                    end
                end
            end
        end
    endtask

    initial begin
        bus.rom_ack       = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = 12'd0;
        bus.halt          = 1'b0;
        run_table();
        seq_wrap();
        seq_branch_drain();
        seq_branch_ack();
        seq_halt_branch();
        run_random(3000);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
